pipeline_hazard_controller: RTL and testbench
=============================================

# pipeline_hazard_controller

Central stall/flush sequencer for the five-stage pipeline. Generates the write enables for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus bubble-inject strobes. Resolves three hazard sources:
- load-use data hazards;
- taken branches resolved in EX;
- multi-cycle data-RAM accesses via a req/ready handshake, including a watchdog timeout.

## Interface
- TIMEOUT_CYCLES, default 255: maximum MEM_WAIT cycles before the error state is entered; range 1..65535.
- CNT_WIDTH, default 32: width of the performance counters.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- id_rs1_address, id_rs2_address  in  5  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  source operand is actually read
- ex_rd_address  in  5  destination of the instruction in EX
- ex_mem_read  in  1  instruction in EX is a load
- ex_branch_taken  in  1  branch/jump in EX redirects the PC
- mem_access  in  1  instruction in MEM performs a RAM read or write
- mem_ready  in  1  RAM completes the access this cycle (single-cycle pulse)
- mem_req  out  1  RAM request
- pc_wren, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren  out  1  stage write enables
- if_id_bubble, id_ex_bubble  out  1  replace that register's input with a NOP (reg_write=0, mem_access=0)
- mem_timeout  out  1  sticky error flag
- stall_mem_count, stall_load_count, flush_count  out  CNT_WIDTH  performance counters (only when compiled in)

## Operation
FSM states are IDLE, MEM_WAIT and ERROR.
- **IDLE:** mem_req = mem_access.
  - mem_access=1 and mem_ready=1: zero-wait access. No stall; remain in IDLE.
  - mem_access=1 and mem_ready=0: freeze all stages (every wren=0, both bubbles=0). Go to MEM_WAIT and clear the wait counter.
- **MEM_WAIT:**
  - mem_req=1; all wren=0.
  - The wait counter increments each cycle.
  - On mem_ready=1: all stages advance that cycle (MEM/WB captures the RAM data) and the FSM returns to IDLE.
  - When the counter reaches TIMEOUT_CYCLES without mem_ready: go to ERROR.
- **ERROR:** all wren=0, mem_req=0, mem_timeout=1. Only reset exits this state.

When not frozen by memory, hazard handling is:
- **Load-use:** asserted when ex_mem_read=1, ex_rd_address≠0 and (id_uses_rs1 with rs1 match, or id_uses_rs2 with rs2 match).
  - pc_wren=0, if_id_wren=0, id_ex_wren=1, id_ex_bubble=1.
  - ex_mem_wren=mem_wb_wren=1.
- **Taken branch:** pc_wren=1, all stage wrens=1, if_id_bubble=1, id_ex_bubble=1.
- **Otherwise:** all wren=1, bubbles=0.

Priority, highest first: memory freeze/ERROR, then taken branch, then load-use. A simultaneous branch and load-use is handled as branch only, because the ID instruction is flushed anyway.

## Timing
- Output decode is combinational from the FSM state and current inputs; there is no added latency.
- State, wait counter and perf counters are registered on the posedge of clk.
- While reset_n=0: every output is 0 (including all wren and mem_req). The registered values clear at the edge: state=IDLE, counters=0, mem_timeout=0.
- Reset asserted mid-MEM_WAIT abandons the access; mem_req drops in the same cycle.
- mem_ready while mem_req=0 is ignored.
- A load-use stall lasts exactly 1 cycle, provided EX receives the bubble.
- A branch costs 2 flushed slots.
- Behaviour at the timeout boundary, measured in cycles after the request first asserts:
  - mem_ready arriving on cycle TIMEOUT_CYCLES is accepted;
  - mem_timeout asserts on cycle TIMEOUT_CYCLES+1.

## Configuration
- Macro PIPELINE_HAZARD_CONTROLLER_PERF_EN.
- **Defined:** the three counters exist.
  - stall_mem_count: +1 per frozen cycle (IDLE miss cycle and MEM_WAIT cycles, excluding the completing cycle).
  - stall_load_count: +1 per load-use stall cycle.
  - flush_count: +1 per taken branch.
  - All three saturate at all-ones.
- **Undefined:** the counter ports are absent and no counter logic is synthesized.

## Structure
- Shared package pipeline_ctrl_pkg: FSM state enum (IDLE, MEM_WAIT, ERROR), REG_ADDR_WIDTH=5, the zero-register constant, and the default TIMEOUT_CYCLES.
- Sub-module load_use_detector: purely combinational register-match logic, reusable by the forwarding unit.

## Test plan
- ex_mem_read=1, ex_rd=5, id_rs1=5, uses_rs1=1 -> one cycle of pc_wren=0, if_id_wren=0, id_ex_bubble=1; next cycle all wren=1.
- Same as above but ex_rd=0 -> no stall.
- ex_branch_taken=1 together with a load-use match -> if_id_bubble=id_ex_bubble=1, pc_wren=1; stall_load_count unchanged, flush_count +1.
- mem_access=1, mem_ready after 3 cycles -> mem_req high 4 cycles and all wren=0 for 3 cycles; the 4th cycle has all wren=1, FSM returns to IDLE, and stall_mem_count=3.
- TIMEOUT_CYCLES=4, mem_ready never arrives -> ERROR with mem_timeout=1 and mem_req=0. Both stay there indefinitely; reset_n=0 for one edge clears them to IDLE.
- reset_n=0 during MEM_WAIT -> mem_req=0 immediately; after release, state=IDLE and all counters=0.

Source files
------------

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer and its helpers.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } ctrl_state_t;

    localparam int REG_ADDR_WIDTH = 5;
    localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = '0;
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Data-RAM request/ready handshake seen by the hazard controller.
// master = controller side, slave = memory/environment side.
interface pipeline_hazard_controller_if;

    logic mem_access;
    logic mem_ready;
    logic mem_req;

    modport master (
        input  mem_access,
        input  mem_ready,
        output mem_req
    );

    modport slave (
        output mem_access,
        output mem_ready,
        input  mem_req
    );

endinterface

// File: rtl/pipeline_hazard_controller_load_use_detector.sv
// Combinational load-use match between the ID sources and the load in EX.
// Register 0 never carries a dependency.
module load_use_detector
    import pipeline_ctrl_pkg::*;
(
    input  logic [REG_ADDR_WIDTH-1:0] i_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs2,
    input  logic                      i_uses_rs1,
    input  logic                      i_uses_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] i_ex_rd,
    input  logic                      i_ex_mem_read,
    output logic                      o_hazard
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = i_uses_rs1 && (i_rs1 == i_ex_rd);
    assign w_rs2_hit = i_uses_rs2 && (i_rs2 == i_ex_rd);
    assign o_hazard  = i_ex_mem_read && (i_ex_rd != ZERO_REG) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the five-stage pipeline: memory freeze FSM with watchdog,
// taken-branch flush and load-use stall. Counters compiled in by PIPELINE_HAZARD_CONTROLLER_PERF_EN.
module pipeline_hazard_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`ifdef PIPELINE_HAZARD_CONTROLLER_PERF_EN
  , parameter int CNT_WIDTH      = 32
`endif
)
(
    input  logic                             clk,
    input  logic                             reset_n,
    pipeline_hazard_controller_if.master     mem_if,
    input  logic [REG_ADDR_WIDTH-1:0]        id_rs1_address,
    input  logic [REG_ADDR_WIDTH-1:0]        id_rs2_address,
    input  logic                             id_uses_rs1,
    input  logic                             id_uses_rs2,
    input  logic [REG_ADDR_WIDTH-1:0]        ex_rd_address,
    input  logic                             ex_mem_read,
    input  logic                             ex_branch_taken,
    output logic                             pc_wren,
    output logic                             if_id_wren,
    output logic                             id_ex_wren,
    output logic                             ex_mem_wren,
    output logic                             mem_wb_wren,
    output logic                             if_id_bubble,
    output logic                             id_ex_bubble,
    output logic                             mem_timeout
`ifdef PIPELINE_HAZARD_CONTROLLER_PERF_EN
  , output logic [CNT_WIDTH-1:0]             stall_mem_count,
    output logic [CNT_WIDTH-1:0]             stall_load_count,
    output logic [CNT_WIDTH-1:0]             flush_count
`endif
);

    ctrl_state_t r_state;
    ctrl_state_t w_next_state;
    logic [15:0] r_wait_cnt;
    logic        w_last_wait;
    logic        w_freeze;
    logic        w_load_use;
    logic        w_mem_req;

    load_use_detector u_load_use (
        .i_rs1         (id_rs1_address),
        .i_rs2         (id_rs2_address),
        .i_uses_rs1    (id_uses_rs1),
        .i_uses_rs2    (id_uses_rs2),
        .i_ex_rd       (ex_rd_address),
        .i_ex_mem_read (ex_mem_read),
        .o_hazard      (w_load_use)
    );

    // Wait counter holds (cycle index - 2) in MEM_WAIT; the first request cycle is spent in IDLE.
    assign w_last_wait = (int'(r_wait_cnt) + 2) >= TIMEOUT_CYCLES;

    always_comb begin
        w_next_state = r_state;
        w_mem_req    = 1'b0;
        w_freeze     = 1'b0;
        pc_wren      = 1'b0;
        if_id_wren   = 1'b0;
        id_ex_wren   = 1'b0;
        ex_mem_wren  = 1'b0;
        mem_wb_wren  = 1'b0;
        if_id_bubble = 1'b0;
        id_ex_bubble = 1'b0;
        mem_timeout  = 1'b0;

        case (r_state)
            IDLE: begin
                w_mem_req = mem_if.mem_access;
                if (mem_if.mem_access && !mem_if.mem_ready) begin
                    w_freeze     = 1'b1;
                    w_next_state = (TIMEOUT_CYCLES == 1) ? ERROR : MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                w_mem_req = 1'b1;
                if (mem_if.mem_ready) begin
                    w_next_state = IDLE;
                end else begin
                    w_freeze = 1'b1;
                    if (w_last_wait) w_next_state = ERROR;
                end
            end
            ERROR: begin
                w_freeze    = 1'b1;
                mem_timeout = 1'b1;
            end
            default: begin
                w_freeze     = 1'b1;
                w_next_state = IDLE;
            end
        endcase

        // Branch outranks load-use: the ID instruction is flushed anyway.
        if (!w_freeze) begin
            if (ex_branch_taken) begin
                pc_wren      = 1'b1;
                if_id_wren   = 1'b1;
                id_ex_wren   = 1'b1;
                ex_mem_wren  = 1'b1;
                mem_wb_wren  = 1'b1;
                if_id_bubble = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (w_load_use) begin
                id_ex_wren   = 1'b1;
                ex_mem_wren  = 1'b1;
                mem_wb_wren  = 1'b1;
                id_ex_bubble = 1'b1;
            end else begin
                pc_wren      = 1'b1;
                if_id_wren   = 1'b1;
                id_ex_wren   = 1'b1;
                ex_mem_wren  = 1'b1;
                mem_wb_wren  = 1'b1;
            end
        end

        if (!reset_n) begin
            w_mem_req    = 1'b0;
            pc_wren      = 1'b0;
            if_id_wren   = 1'b0;
            id_ex_wren   = 1'b0;
            ex_mem_wren  = 1'b0;
            mem_wb_wren  = 1'b0;
            if_id_bubble = 1'b0;
            id_ex_bubble = 1'b0;
            mem_timeout  = 1'b0;
        end
    end

    assign mem_if.mem_req = w_mem_req;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == MEM_WAIT) r_wait_cnt <= r_wait_cnt + 16'd1;
            else                     r_wait_cnt <= '0;
        end
    end

`ifdef PIPELINE_HAZARD_CONTROLLER_PERF_EN
    logic                 w_mem_stall;
    logic                 w_load_stall;
    logic                 w_flush;
    logic [CNT_WIDTH-1:0] r_stall_mem_cnt;
    logic [CNT_WIDTH-1:0] r_stall_load_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // ERROR cycles are frozen too but are not counted as memory stalls.
    assign w_mem_stall  = ((r_state == IDLE) && mem_if.mem_access && !mem_if.mem_ready) ||
                          ((r_state == MEM_WAIT) && !mem_if.mem_ready);
    assign w_load_stall = !w_freeze && !ex_branch_taken && w_load_use;
    assign w_flush      = !w_freeze && ex_branch_taken;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stall_mem_cnt  <= '0;
            r_stall_load_cnt <= '0;
            r_flush_cnt      <= '0;
        end else begin
            if (w_mem_stall)  r_stall_mem_cnt  <= sat_inc(r_stall_mem_cnt);
            if (w_load_stall) r_stall_load_cnt <= sat_inc(r_stall_load_cnt);
            if (w_flush)      r_flush_cnt      <= sat_inc(r_flush_cnt);
        end
    end

    assign stall_mem_count  = r_stall_mem_cnt;
    assign stall_load_count = r_stall_load_cnt;
    assign flush_count      = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed scoreboard bench for pipeline_hazard_controller (TIMEOUT_CYCLES=4).
module tb_pipeline_hazard_controller;

    localparam int TO = 4;

    // {mem_req, pc, if_id, id_ex, ex_mem, mem_wb, if_id_bub, id_ex_bub, mem_timeout}
    localparam logic [8:0] E_RST     = 9'b0_00000_00_0;
    localparam logic [8:0] E_RUN     = 9'b0_11111_00_0;
    localparam logic [8:0] E_LU      = 9'b0_00111_01_0;
    localparam logic [8:0] E_BR      = 9'b0_11111_11_0;
    localparam logic [8:0] E_RUN_REQ = 9'b1_11111_00_0;
    localparam logic [8:0] E_FRZ_REQ = 9'b1_00000_00_0;
    localparam logic [8:0] E_ERR     = 9'b0_00000_00_1;

    typedef struct {
        string      tag;
        logic [8:0] exp;
    } sb_item_t;

    logic       clk;
    logic       reset_n;
    logic [4:0] id_rs1_address, id_rs2_address, ex_rd_address;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
    logic       pc_wren, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren;
    logic       if_id_bubble, id_ex_bubble, mem_timeout;
`ifdef PIPELINE_HAZARD_CONTROLLER_PERF_EN
    logic [31:0] stall_mem_count, stall_load_count, flush_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    sb_item_t sb[$];

    pipeline_hazard_controller_if mif();

    pipeline_hazard_controller #(.TIMEOUT_CYCLES(TO)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .mem_if          (mif.master),
        .id_rs1_address  (id_rs1_address),
        .id_rs2_address  (id_rs2_address),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rd_address   (ex_rd_address),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .pc_wren         (pc_wren),
        .if_id_wren      (if_id_wren),
        .id_ex_wren      (id_ex_wren),
        .ex_mem_wren     (ex_mem_wren),
        .mem_wb_wren     (mem_wb_wren),
        .if_id_bubble    (if_id_bubble),
        .id_ex_bubble    (id_ex_bubble),
        .mem_timeout     (mem_timeout)
`ifdef PIPELINE_HAZARD_CONTROLLER_PERF_EN
      , .stall_mem_count (stall_mem_count),
        .stall_load_count(stall_load_count),
        .flush_count     (flush_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    wire [8:0] obs = {mif.mem_req, pc_wren, if_id_wren, id_ex_wren, ex_mem_wren,
                      mem_wb_wren, if_id_bubble, id_ex_bubble, mem_timeout};

    task automatic neutral();
        id_rs1_address  = 5'd1;
        id_rs2_address  = 5'd2;
        id_uses_rs1     = 1'b0;
        id_uses_rs2     = 1'b0;
        ex_rd_address   = 5'd3;
        ex_mem_read     = 1'b0;
        ex_branch_taken = 1'b0;
        mif.mem_access  = 1'b0;
        mif.mem_ready   = 1'b0;
    endtask

    // Inputs are already driven; push the expectation, compare at negedge, advance past posedge.
    task automatic step(input string tag, input logic [8:0] exp);
        sb_item_t it;
        sb_item_t got;
        it.tag = tag;
        it.exp = exp;
        sb.push_back(it);
        @(negedge clk);
        got = sb.pop_front();
        n_checks++;
        assert (obs === got.exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", got.tag, obs, got.exp);
        end
        @(posedge clk);
        #1;
    endtask

`ifdef PIPELINE_HAZARD_CONTROLLER_PERF_EN
    task automatic chk_cnt(input string tag, input int em, input int el, input int ef);
        logic [95:0] o;
        logic [95:0] e;
        o = {stall_mem_count, stall_load_count, flush_count};
        e = {32'(em), 32'(el), 32'(ef)};
        n_checks++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed mem/load/flush %0d/%0d/%0d expected %0d/%0d/%0d",
                   tag, stall_mem_count, stall_load_count, flush_count, em, el, ef);
        end
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        neutral();
        mif.mem_access  = 1'b1;
        ex_branch_taken = 1'b1;
        step("reset_outputs_0", E_RST);
        step("reset_outputs_1", E_RST);
        reset_n = 1'b1;
        neutral();
        step("idle_run", E_RUN);
`ifdef PIPELINE_HAZARD_CONTROLLER_PERF_EN
        chk_cnt("cnt_after_reset", 0, 0, 0);
`endif

        // Load-use on rs1, then EX holds the bubble
        ex_mem_read = 1'b1; ex_rd_address = 5'd5; id_rs1_address = 5'd5; id_uses_rs1 = 1'b1;
        step("load_use_rs1", E_LU);
        neutral();
        step("load_use_release", E_RUN);
`ifdef PIPELINE_HAZARD_CONTROLLER_PERF_EN
        chk_cnt("cnt_load_use", 0, 1, 0);
`endif
        ex_mem_read = 1'b1; ex_rd_address = 5'd0; id_rs1_address = 5'd0; id_uses_rs1 = 1'b1;
        step("load_rd_zero", E_RUN);
        neutral();
        ex_mem_read = 1'b1; ex_rd_address = 5'd7; id_rs2_address = 5'd7; id_uses_rs2 = 1'b1;
        step("load_use_rs2", E_LU);
        id_uses_rs2 = 1'b0;
        step("rs2_not_used", E_RUN);
        id_uses_rs2 = 1'b1; ex_mem_read = 1'b0;
        step("no_load_match", E_RUN);

        // Branch together with load-use: branch only
        ex_mem_read = 1'b1; ex_rd_address = 5'd9; id_rs1_address = 5'd9; id_uses_rs1 = 1'b1;
        ex_branch_taken = 1'b1;
        step("branch_and_load_use", E_BR);
`ifdef PIPELINE_HAZARD_CONTROLLER_PERF_EN
        chk_cnt("cnt_branch_lu", 0, 2, 1);
`endif
        neutral();
        ex_branch_taken = 1'b1;
        step("branch_only", E_BR);

        neutral();
        mif.mem_access = 1'b1; mif.mem_ready = 1'b1;
        step("zero_wait_access", E_RUN_REQ);
        mif.mem_access = 1'b0; mif.mem_ready = 1'b1;
        step("ready_without_req", E_RUN);

        // Multi-cycle access completing on cycle TO (boundary accepted)
        neutral();
        mif.mem_access = 1'b1;
        step("mem_miss_c1", E_FRZ_REQ);
        ex_branch_taken = 1'b1;
        step("mem_wait_c2_branch", E_FRZ_REQ);
        ex_branch_taken = 1'b0;
        step("mem_wait_c3", E_FRZ_REQ);
        mif.mem_ready = 1'b1;
        step("mem_done_c4", E_RUN_REQ);
        neutral();
        step("mem_back_idle", E_RUN);
`ifdef PIPELINE_HAZARD_CONTROLLER_PERF_EN
        chk_cnt("cnt_mem_wait", 3, 2, 2);
`endif

        // Reset in the middle of MEM_WAIT
        mif.mem_access = 1'b1;
        step("mem_miss_pre_rst", E_FRZ_REQ);
        mif.mem_access = 1'b0;
        step("mem_wait_pre_rst", E_FRZ_REQ);
        reset_n = 1'b0;
        step("rst_in_mem_wait", E_RST);
        reset_n = 1'b1;
        step("idle_after_rst", E_RUN);
`ifdef PIPELINE_HAZARD_CONTROLLER_PERF_EN
        chk_cnt("cnt_after_mid_rst", 0, 0, 0);
`endif

        // Watchdog: no ready ever arrives
        mif.mem_access = 1'b1;
        for (int i = 1; i <= TO; i++) step($sformatf("to_wait_c%0d", i), E_FRZ_REQ);
        step("to_error_entry", E_ERR);
        mif.mem_ready = 1'b1;
        step("error_ignores_ready", E_ERR);
        mif.mem_ready = 1'b0; mif.mem_access = 1'b0; ex_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) step($sformatf("error_sticky_%0d", i), E_ERR);
        neutral();
        reset_n = 1'b0;
        step("error_reset", E_RST);
        reset_n = 1'b1;
        step("error_cleared", E_RUN);
        mif.mem_access = 1'b1; mif.mem_ready = 1'b1;
        step("post_error_zero_wait", E_RUN_REQ);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
